// File: rtl/ysyx_22040759_mem_stage.sv
// MEM stage: captures EX bus, runs load/store over req/gnt/rvalid, extracts load data, hands off to WB.
// Non-memory ops take 1 cycle, memory ops at least 3; WB backpressure freezes the held instruction.
`ifndef WREG_ALU
`define WREG_ALU 2'd0
`endif
`ifndef WREG_RAM
`define WREG_RAM 2'd1
`endif
`ifndef WREG_PC
`define WREG_PC 2'd2
`endif

module ysyx_22040759_mem_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         es_to_ms_valid,
  input  logic [236:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [231:0] ms_to_ws_bus,
  output logic [70:0]  ms_to_ds_fwd_bus,
  output logic         data_req,
  output logic         data_we,
  output logic [63:0]  data_addr,
  output logic [7:0]   data_wmask,
  output logic [63:0]  data_wdata,
  input  logic         data_gnt,
  input  logic         data_rvalid,
  input  logic [63:0]  data_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic         ms_valid_q, ms_valid_d;
  logic [236:0] bus_q, bus_d;
  logic [1:0]   state_q, state_d;
  logic [63:0]  rdata_q, rdata_d;

  logic [31:0] inst;
  logic        reg_wen;
  logic [4:0]  rd;
  logic [1:0]  wreg_sel;
  logic        mem_re, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic [63:0] store_data, alu_result, pc;

  assign inst         = bus_q[236:205];
  assign reg_wen      = bus_q[204];
  assign rd           = bus_q[203:199];
  assign wreg_sel     = bus_q[198:197];
  assign mem_re       = bus_q[196];
  assign mem_we       = bus_q[195];
  assign mem_size     = bus_q[194:193];
  assign mem_unsigned = bus_q[192];
  assign store_data   = bus_q[191:128];
  assign alu_result   = bus_q[127:64];
  assign pc           = bus_q[63:0];

  logic       mem_op, es_mem_op, ms_ready_go, capture;
  logic [2:0] off;
  logic [5:0] sh;

  assign mem_op      = mem_re | mem_we;
  assign es_mem_op   = es_to_ms_bus[196] | es_to_ms_bus[195];
  assign ms_ready_go = !mem_op || (state_q == S_DONE);
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign capture     = es_to_ms_valid && ms_allowin;
  assign off         = alu_result[2:0];
  assign sh          = {off, 3'b000};

  logic [7:0] base_mask;
  always_comb begin
    case (mem_size)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign data_req   = (state_q == S_REQ);
  assign data_we    = mem_we;
  assign data_addr  = {alu_result[63:3], 3'b000};
  assign data_wmask = mem_we ? (base_mask << off) : 8'h00;
  assign data_wdata = store_data << sh;

  // Shifting right fills the upper lanes with zeros, so bytes past bit 63 read as 0.
  logic [63:0] ld_raw, ld_ext;
  assign ld_raw = data_rdata >> sh;
  always_comb begin
    case (mem_size)
      2'd0:    ld_ext = mem_unsigned ? {56'd0, ld_raw[7:0]}  : {{56{ld_raw[7]}},  ld_raw[7:0]};
      2'd1:    ld_ext = mem_unsigned ? {48'd0, ld_raw[15:0]} : {{48{ld_raw[15]}}, ld_raw[15:0]};
      2'd2:    ld_ext = mem_unsigned ? {32'd0, ld_raw[31:0]} : {{32{ld_raw[31]}}, ld_raw[31:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    state_d    = state_q;
    rdata_d    = rdata_q;
    if (ms_allowin) ms_valid_d = es_to_ms_valid;
    if (capture) begin
      bus_d   = es_to_ms_bus;
      state_d = es_mem_op ? S_REQ : S_IDLE;
    end else if (ms_allowin) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_REQ:  if (data_gnt) state_d = S_RESP;
        S_RESP: if (data_rvalid) begin
          state_d = S_DONE;
          rdata_d = ld_ext;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
      state_q    <= S_IDLE;
      rdata_q    <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      bus_q      <= bus_d;
      state_q    <= state_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign ms_to_ws_bus   = {inst, reg_wen, rd, wreg_sel, rdata_q, alu_result, pc};

  logic        fwd_wen, fwd_stall;
  logic [63:0] fwd_data;
  assign fwd_wen   = ms_valid_q && reg_wen;
  assign fwd_stall = fwd_wen && (wreg_sel == `WREG_RAM) && !ms_ready_go;
  always_comb begin
    case (wreg_sel)
      `WREG_PC:  fwd_data = pc + 64'd4;
      `WREG_ALU: fwd_data = alu_result;
      `WREG_RAM: fwd_data = rdata_q;
      default:   fwd_data = 64'd0;
    endcase
  end
  assign ms_to_ds_fwd_bus = {fwd_stall, fwd_wen, rd, fwd_data};

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Bench for ysyx_22040759_mem_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_ysyx_22040759_mem_stage;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_RAM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;

  logic         clk, rst;
  logic         es_to_ms_valid, ws_allowin;
  logic [236:0] es_to_ms_bus;
  logic         ms_allowin, ms_to_ws_valid;
  logic [231:0] ms_to_ws_bus;
  logic [70:0]  ms_to_ds_fwd_bus;
  logic         data_req, data_we, data_gnt, data_rvalid;
  logic [63:0]  data_addr, data_wdata, data_rdata;
  logic [7:0]   data_wmask;

  ysyx_22040759_mem_stage dut (
    .clk(clk), .rst(rst),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .ms_allowin(ms_allowin),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_to_ds_fwd_bus(ms_to_ds_fwd_bus),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wmask(data_wmask),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [236:0] mk(input logic [31:0] inst, input logic wen, input logic [4:0] rd,
                                      input logic [1:0] sel, input logic re, input logic we,
                                      input logic [1:0] sz, input logic uns, input logic [63:0] sd,
                                      input logic [63:0] alu, input logic [63:0] pc);
    return {inst, wen, rd, sel, re, we, sz, uns, sd, alu, pc};
  endfunction

  // Byte-by-byte view of load/store semantics.
  function automatic logic [63:0] ld_model(input logic [63:0] raw, input int off, input int sz, input bit uns);
    logic [63:0] v;
    int n;
    n = 1 << sz;
    v = 64'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v = v + ({56'd0, raw[(off+i)*8 +: 8]} << (8*i));
    if (!uns && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  function automatic logic [7:0] mask_model(input int off, input int sz, input bit we);
    logic [7:0] m;
    m = 8'd0;
    if (we)
      for (int i = 0; i < (1 << sz); i++)
        if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] wdata_model(input logic [63:0] sd, input int off);
    logic [63:0] w;
    w = 64'd0;
    for (int j = off; j < 8; j++) w[j*8 +: 8] = sd[(j-off)*8 +: 8];
    return w;
  endfunction

  // Model: at most one instruction in the stage, plus whether its access was granted / answered.
  logic [236:0] cur;
  bit           have_cur, granted, got_rv;
  logic [63:0]  last_rdata;

  task automatic model_reset();
    have_cur = 0; granted = 0; got_rv = 0; last_rdata = 64'd0; cur = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    bit mem, rdy, ev, ea, er, fw;
    logic [63:0] exp_fd;
    #1;
    mem = have_cur && (cur[196] || cur[195]);
    rdy = !mem || got_rv;
    ev  = have_cur && rdy;
    ea  = !have_cur || (rdy && ws_allowin);
    er  = mem && !granted;
    fw  = have_cur && cur[204];
    chk("ms_to_ws_valid", ms_to_ws_valid, ev);
    chk("ms_allowin", ms_allowin, ea);
    chk("data_req", data_req, er);
    chk("fwd_wen", ms_to_ds_fwd_bus[69], fw);
    chk("fwd_stall", ms_to_ds_fwd_bus[70], fw && cur[198:197] == SEL_RAM && !rdy);
    if (ev)
      chk("ws_bus", ms_to_ws_bus, {cur[236:197], last_rdata, cur[127:0]});
    if (fw && cur[198:197] != 2'd3) begin
      exp_fd = (cur[198:197] == SEL_PC)  ? cur[63:0] + 64'd4 :
               (cur[198:197] == SEL_ALU) ? cur[127:64] : last_rdata;
      chk("fwd_rd", ms_to_ds_fwd_bus[68:64], cur[203:199]);
      chk("fwd_data", ms_to_ds_fwd_bus[63:0], exp_fd);
    end
    if (er) begin
      chk("data_addr", data_addr, {cur[127:67], 3'b000});
      chk("data_we", data_we, cur[195]);
      chk("data_wmask", data_wmask, mask_model(cur[66:64], cur[194:193], cur[195]));
      chk("data_wdata", data_wdata, wdata_model(cur[191:128], cur[66:64]));
    end
    if (data_rvalid && granted && !got_rv) begin
      last_rdata = ld_model(data_rdata, cur[66:64], cur[194:193], cur[192]);
      got_rv = 1;
    end
    if (er && data_gnt) granted = 1;
    if (es_to_ms_valid && ea) begin
      cur = es_to_ms_bus; have_cur = 1; granted = 0; got_rv = 0;
    end else if (ea) begin
      have_cur = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    es_to_ms_valid = 0; data_gnt = 0; data_rvalid = 0;
  endtask

  // Best-case memory op: capture, gnt next cycle, rvalid the one after; returns what the port showed.
  logic [63:0] obs_addr, obs_wdata, obs_rdata;
  logic [7:0]  obs_wmask;
  logic        obs_we;
  task automatic run_best(input logic [236:0] b, input logic [63:0] rdat);
    es_to_ms_valid = 1; es_to_ms_bus = b; ws_allowin = 1;
    step();
    idle_inputs(); data_gnt = 1;
    settle();
    chk("best_req_n1", data_req, 1'b1);
    obs_addr = data_addr; obs_wmask = data_wmask; obs_wdata = data_wdata; obs_we = data_we;
    step();
    data_gnt = 0; data_rvalid = 1; data_rdata = rdat;
    settle();
    chk("best_vld_n2", ms_to_ws_valid, 1'b0);
    step();
    data_rvalid = 0;
    settle();
    chk("best_vld_n3", ms_to_ws_valid, 1'b1);
    obs_rdata = ms_to_ws_bus[191:128];
    step();
  endtask

  initial begin
    rst = 1; ws_allowin = 0; es_to_ms_bus = '0; data_rdata = '0;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_ws_bus", ms_to_ws_bus, 232'd0);
    chk("rst_fwd_bus", ms_to_ds_fwd_bus, 71'd0);
    chk("rst_mem_port", {data_req, data_we, data_addr, data_wmask, data_wdata}, 138'd0);
    @(posedge clk); #1;
    rst = 0;

    // ALU-only stream at full throughput
    ws_allowin = 1;
    for (int i = 0; i < 4; i++) begin
      es_to_ms_valid = (i < 3);
      es_to_ms_bus = mk(32'h13 + i, 1, 5'd1 + i[4:0], SEL_ALU, 0, 0, 0, 0, 0, 64'h1234, 64'h8000_0000);
      settle();
      if (i > 0) begin
        chk("alu_vld", ms_to_ws_valid, 1'b1);
        chk("alu_allowin", ms_allowin, 1'b1);
        chk("alu_res", ms_to_ws_bus[127:64], 64'h1234);
      end
      step();
    end

    // lb / lbu
    run_best(mk(32'h3, 1, 5'd7, SEL_RAM, 1, 0, 2'd0, 0, 0, 64'h8000_1003, 64'h8000_0100), 64'h0000_0000_8000_0000);
    chk("lb_addr", obs_addr, 64'h8000_1000);
    chk("lb_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_best(mk(32'h4003, 1, 5'd7, SEL_RAM, 1, 0, 2'd0, 1, 0, 64'h8000_1003, 64'h8000_0104), 64'h0000_0000_8000_0000);
    chk("lbu_rdata", obs_rdata, 64'h80);

    // sh
    run_best(mk(32'h1023, 0, 5'd0, SEL_ALU, 0, 1, 2'd1, 0, 64'hBEEF, 64'h8000_2006, 64'h8000_0108), 64'hDEAD_BEEF_DEAD_BEEF);
    chk("sh_wmask", obs_wmask, 8'hC0);
    chk("sh_wdata", obs_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_we", obs_we, 1'b1);

    // lw to rd=5, gnt after 3 idle cycles, rvalid 2 cycles after that
    es_to_ms_valid = 1;
    es_to_ms_bus = mk(32'h2283, 1, 5'd5, SEL_RAM, 1, 0, 2'd2, 0, 0, 64'h8000_4004, 64'h8000_010C);
    step();
    idle_inputs();
    data_rdata = 64'h8765_4321_0000_0000;
    for (int c = 1; c <= 7; c++) begin
      data_gnt = (c == 4); data_rvalid = (c == 7);
      settle();
      chk("slow_req", data_req, c <= 4);
      chk("slow_allowin", ms_allowin, 1'b0);
      chk("slow_stall", ms_to_ds_fwd_bus[70], 1'b1);
      step();
    end
    idle_inputs();

    // WB backpressure while DONE
    ws_allowin = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("bp_vld", ms_to_ws_valid, 1'b1);
      chk("bp_allowin", ms_allowin, 1'b0);
      chk("bp_rdata", ms_to_ws_bus[191:128], 64'hFFFF_FFFF_8765_4321);
      chk("bp_fwd", ms_to_ds_fwd_bus, {1'b0, 1'b1, 5'd5, 64'hFFFF_FFFF_8765_4321});
      step();
    end
    ws_allowin = 1; es_to_ms_valid = 1;
    es_to_ms_bus = mk(32'h3083, 1, 5'd9, SEL_RAM, 1, 0, 2'd3, 0, 0, 64'h8000_5000, 64'h8000_0110);
    settle();
    chk("bp_release_allowin", ms_allowin, 1'b1);
    step();
    idle_inputs(); data_gnt = 1;
    settle();
    chk("bp_next_req", data_req, 1'b1);
    step();

    // async reset while in RESP
    idle_inputs(); rst = 1;
    settle();
    chk("arst_req", data_req, 1'b0);
    chk("arst_vld", ms_to_ws_valid, 1'b0);
    chk("arst_fwd", ms_to_ds_fwd_bus, 71'd0);
    model_reset();
    step();
    rst = 0; data_rvalid = 1; data_rdata = 64'h1111_2222_3333_4444;
    for (int c = 0; c < 3; c++) step();
    settle();
    chk("arst_late_rv", ms_to_ws_valid, 1'b0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      es_to_ms_valid = ($urandom_range(0, 9) < 6);
      es_to_ms_bus = mk($urandom, 1'($urandom), 5'($urandom), 2'($urandom_range(0, 2)),
                        kind == 1, kind == 2, 2'($urandom), 1'($urandom),
                        {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      ws_allowin  = ($urandom_range(0, 9) < 7);
      data_gnt    = 1'($urandom);
      data_rvalid = 1'($urandom);
      data_rdata  = {$urandom, $urandom};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
